gate_timing_controller: RTL and testbench
=========================================

# gate_timing_controller

Sequencer that runs fixed-length gate-time measurements on the synchronous event counter. It clears the counter, enables it for exactly `GATE_CYCLES` clocks, latches the final count and flags wrap-around. It then holds the result and `data_ready` until the MicroBlaze MCS acknowledges through a GPO bit. It sits between the one-shot/event-counter datapath and the MCS GPIO inputs, and replaces free-running counting with repeatable, software-paced samples.

## Interface
- `GATE_CYCLES`, default 100000000: gate length in clocks (1 s at 100 MHz); legal range ≥ 1.
- `WIDTH`, default 32: counter/result width.
- `clk` input 1: system clock; all logic on rising edge.
- `reset` input 1: synchronous, active-low reset.
- `start` input 1: level, sampled in IDLE; launches one measurement.
- `continuous` input 1: when 1, IDLE launches automatically and the post-ack state is CLEAR.
- `abort` input 1: forces IDLE from any state.
- `ack` input 1: MCS acknowledge, level, sampled in HOLD.
- `cnt_value` input WIDTH: live value of the external event counter.
- `cnt_clear` output 1: synchronous clear to the event counter.
- `cnt_enable` output 1: count-enable to the event counter.
- `result` output WIDTH: latched count.
- `data_ready` output 1: result valid, awaiting ack.
- `overflow` output 1: counter wrapped during the measurement that produced `result`.
- `busy` output 1: state ≠ IDLE.
- `state` output 3: debug; IDLE=0, CLEAR=1, GATE=2, SETTLE=3, HOLD=4.

## Operation
- Moore FSM. `cnt_clear` = (state==CLEAR). `cnt_enable` = (state==GATE). `data_ready` = (state==HOLD).
- IDLE → CLEAR when (`start` | `continuous`) & !`abort`.
- CLEAR → GATE unconditionally. This also zeroes the gate timer and the working overflow flag.
- GATE: the gate timer counts 0..GATE_CYCLES-1; at GATE_CYCLES-1 → SETTLE. The timer is sized with $clog2(GATE_CYCLES+1) bits; it never wraps.
- SETTLE: one cycle with enable low, so the counter's final increment is visible. On exit, `result` ← `cnt_value` and `overflow` ← the working flag; → HOLD.
- HOLD: wait indefinitely. `result` and `overflow` are stable. When `ack`=1: → CLEAR if `continuous`, else → IDLE.
- Overflow detection: register the previous `cnt_value`. The working flag sets when the previous value is all-ones and the current value is 0, while state ∈ {GATE, SETTLE}. The flag is sticky until CLEAR. A count ending exactly at all-ones is not an overflow.
- `abort`=1 in any state: next state IDLE. `result`/`overflow` keep their last values. `data_ready` drops with the state. `abort` has priority over `start`, `continuous` and `ack`.
- `start` outside IDLE is ignored; there is no queuing.
- Reset (`reset`=0 at an edge): state IDLE, timer 0, `result` 0, `overflow` 0, working flag 0. All outputs read 0 in the following cycle. Reset mid-gate discards the measurement.

## Timing
- Take `start` high in cycle 0 (sampled at the end of cycle 0).
- Cycle 1: CLEAR, `cnt_clear`=1.
- Cycles 2..GATE_CYCLES+1: `cnt_enable`=1, exactly GATE_CYCLES cycles.
- Cycle GATE_CYCLES+2: SETTLE.
- Cycle GATE_CYCLES+3 onward: `data_ready`=1 and `result` valid in the same cycle.
- `ack` sampled high in HOLD cycle k: `data_ready`=0 in cycle k+1.
- Continuous mode with `ack` held high: one measurement every GATE_CYCLES+3 cycles; `cnt_clear` recurs at that period.
- `abort` sampled in cycle k: IDLE, `cnt_enable`=0 and `cnt_clear`=0 in cycle k+1.
- No combinational path from inputs to outputs.

## Test plan
- Reset: hold `reset`=0 two cycles with `start`=1 → all outputs 0, `state`=0, `busy`=0 on the cycle after release.
- Single shot, GATE_CYCLES=10, counter model increments every enabled cycle:
  - `start` pulse in cycle 0 → `cnt_clear` high only in cycle 1.
  - `cnt_enable` high in cycles 2–11.
  - `data_ready`=1 from cycle 13, `result`=10, `overflow`=0.
- Handshake: keep `ack`=0 for 50 cycles in HOLD → `data_ready`, `result`=10 stable; `ack`=1 → `data_ready`=0 next cycle, `state`=IDLE, `busy`=0.
- Continuous, GATE_CYCLES=10, `ack` tied high → `cnt_clear` pulses every 13 cycles, each `result`=10; `continuous`→0 → returns to IDLE after the current HOLD.
- Abort: `abort`=1 in gate cycle 6 (with `start`=1) → cycle 7 IDLE, `cnt_enable`=0, `data_ready`=0, previous `result` unchanged; no restart while `abort`=1.
- Overflow, WIDTH=4, GATE_CYCLES=20 → `result`=4, `overflow`=1. Then GATE_CYCLES=15 → `result`=15, `overflow`=0.

Source files
------------

// File: rtl/gate_timing_controller.sv
// Gate-time measurement sequencer: clears the event counter, enables it for exactly
// GATE_CYCLES clocks, latches the final count plus a wrap flag, and holds until acknowledged.
module gate_timing_controller #(
  parameter int unsigned GATE_CYCLES = 100000000,
  parameter int unsigned WIDTH       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             continuous,
  input  logic             abort,
  input  logic             ack,
  input  logic [WIDTH-1:0] cnt_value,
  output logic             cnt_clear,
  output logic             cnt_enable,
  output logic [WIDTH-1:0] result,
  output logic             data_ready,
  output logic             overflow,
  output logic             busy,
  output logic [2:0]       state
);

  localparam int unsigned TW = $clog2(GATE_CYCLES + 1);
  localparam logic [TW-1:0] LAST_TICK = TW'(GATE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_GATE   = 3'd2,
    S_SETTLE = 3'd3,
    S_HOLD   = 3'd4
  } state_t;

  state_t           state_q;
  logic [TW-1:0]    timer_q;
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] result_q;
  logic             wflag_q;
  logic             overflow_q;
  logic             wrap_d;

  // The first gate cycle still compares against the pre-clear count, so it is excluded
  // to avoid flagging a previous run that ended at all-ones.
  always_comb begin
    wrap_d = (prev_q == '1) && (cnt_value == '0) &&
             (((state_q == S_GATE) && (timer_q != '0)) || (state_q == S_SETTLE));
  end

  always_ff @(posedge clk) begin
    prev_q <= cnt_value;
    if (!reset) begin
      state_q    <= S_IDLE;
      timer_q    <= '0;
      result_q   <= '0;
      overflow_q <= 1'b0;
      wflag_q    <= 1'b0;
    end else if (abort) begin
      state_q <= S_IDLE;
    end else begin
      if (wrap_d) wflag_q <= 1'b1;
      case (state_q)
        S_IDLE: begin
          if (start || continuous) state_q <= S_CLEAR;
        end
        S_CLEAR: begin
          timer_q <= '0;
          wflag_q <= 1'b0;
          state_q <= S_GATE;
        end
        S_GATE: begin
          timer_q <= timer_q + TW'(1);
          if (timer_q == LAST_TICK) state_q <= S_SETTLE;
        end
        S_SETTLE: begin
          result_q   <= cnt_value;
          overflow_q <= wflag_q | wrap_d;
          state_q    <= S_HOLD;
        end
        S_HOLD: begin
          if (ack) state_q <= continuous ? S_CLEAR : S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cnt_clear  = (state_q == S_CLEAR);
  assign cnt_enable = (state_q == S_GATE);
  assign data_ready = (state_q == S_HOLD);
  assign busy       = (state_q != S_IDLE);
  assign state      = state_q;
  assign result     = result_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_gate_timing_controller.sv
// Directed bench: a 10-clock gate on a 32-bit counter, plus 4-bit counters gated for 20 and 15 clocks.
module tb_gate_timing_controller;

  logic clk = 1'b0;
  logic reset, start, continuous, abort, ack, start2, ack2;
  int   checks = 0;
  int   errors = 0;

  logic [31:0] cnt = '0;
  logic        clr, en, rdy, ovf, bsy;
  logic [31:0] res;
  logic [2:0]  st;

  logic [3:0]  cnt20 = '0, cnt15 = '0;
  logic        clr20, en20, rdy20, ovf20, bsy20, clr15, en15, rdy15, ovf15, bsy15;
  logic [3:0]  res20, res15;
  logic [2:0]  st20, st15;

  always #5 clk = ~clk;

  gate_timing_controller #(.GATE_CYCLES(10), .WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .continuous(continuous), .abort(abort), .ack(ack),
    .cnt_value(cnt), .cnt_clear(clr), .cnt_enable(en), .result(res), .data_ready(rdy),
    .overflow(ovf), .busy(bsy), .state(st));

  gate_timing_controller #(.GATE_CYCLES(20), .WIDTH(4)) dut20 (
    .clk(clk), .reset(reset), .start(start2), .continuous(1'b0), .abort(1'b0), .ack(ack2),
    .cnt_value(cnt20), .cnt_clear(clr20), .cnt_enable(en20), .result(res20), .data_ready(rdy20),
    .overflow(ovf20), .busy(bsy20), .state(st20));

  gate_timing_controller #(.GATE_CYCLES(15), .WIDTH(4)) dut15 (
    .clk(clk), .reset(reset), .start(start2), .continuous(1'b0), .abort(1'b0), .ack(ack2),
    .cnt_value(cnt15), .cnt_clear(clr15), .cnt_enable(en15), .result(res15), .data_ready(rdy15),
    .overflow(ovf15), .busy(bsy15), .state(st15));

  // External event counters: one event per enabled clock
  always_ff @(posedge clk) begin
    if (clr) cnt <= '0; else if (en) cnt <= cnt + 32'd1;
    if (clr20) cnt20 <= '0; else if (en20) cnt20 <= cnt20 + 4'd1;
    if (clr15) cnt15 <= '0; else if (en15) cnt15 <= cnt15 + 4'd1;
  end

  task automatic test_reset;
    reset = 1'b0; start = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1; start = 1'b0;
    @(negedge clk);
    checks++;
    if ({clr, en, rdy, ovf, bsy, st, res} !== 40'd0) begin
      errors++; $display("FAIL reset_main got %h want 0", {clr, en, rdy, ovf, bsy, st, res});
    end
    checks++;
    if ({clr20, en20, rdy20, ovf20, bsy20, st20, res20, clr15, en15, rdy15, ovf15, bsy15, st15, res15} !== 24'd0) begin
      errors++; $display("FAIL reset_ovf_duts got %h want 0",
        {clr20, en20, rdy20, ovf20, bsy20, st20, res20, clr15, en15, rdy15, ovf15, bsy15, st15, res15});
    end
  endtask

  task automatic test_single_shot;
    logic [5:0] exp_v;
    @(negedge clk); start = 1'b1;
    for (int c = 1; c <= 13; c++) begin
      @(negedge clk); start = 1'b0;
      exp_v[5]   = (c == 1);
      exp_v[4]   = (c >= 2 && c <= 11);
      exp_v[3]   = (c == 13);
      exp_v[2:0] = (c == 1) ? 3'd1 : (c <= 11) ? 3'd2 : (c == 12) ? 3'd3 : 3'd4;
      checks++;
      if ({clr, en, rdy, st} !== exp_v) begin
        errors++; $display("FAIL single_shot_c%0d clr/en/rdy/st got %b want %b", c, {clr, en, rdy, st}, exp_v);
      end
    end
    checks++;
    if ({ovf, res} !== {1'b0, 32'd10}) begin
      errors++; $display("FAIL single_shot_result got ovf=%b res=%0d want ovf=0 res=10", ovf, res);
    end
  endtask

  task automatic test_handshake;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      checks++;
      if ({rdy, ovf, res} !== {1'b1, 1'b0, 32'd10}) begin
        errors++; $display("FAIL hold_stable_%0d got rdy=%b ovf=%b res=%0d want 1 0 10", i, rdy, ovf, res);
      end
    end
    ack = 1'b1;
    @(negedge clk); ack = 1'b0;
    checks++;
    if ({rdy, bsy, st} !== 5'd0) begin
      errors++; $display("FAIL ack_release got rdy=%b bsy=%b st=%0d want 0 0 0", rdy, bsy, st);
    end
  endtask

  task automatic test_continuous;
    int n_ready = 0;
    logic [2:0] exp_st;
    @(negedge clk); continuous = 1'b1; ack = 1'b1;
    for (int c = 1; c <= 45; c++) begin
      @(negedge clk);
      checks++;
      if (clr !== ((c - 1) % 13 == 0)) begin
        errors++; $display("FAIL cont_clear_c%0d got %b want %b", c, clr, ((c - 1) % 13 == 0));
      end
      if (rdy === 1'b1) begin
        n_ready++;
        checks++;
        if (res !== 32'd10) begin
          errors++; $display("FAIL cont_result_c%0d got %0d want 10", c, res);
        end
      end
    end
    checks++;
    if (n_ready != 3) begin
      errors++; $display("FAIL cont_ready_count got %0d want 3", n_ready);
    end
    continuous = 1'b0;
    for (int c = 46; c <= 55; c++) begin
      @(negedge clk);
      exp_st = (c <= 50) ? 3'd2 : (c == 51) ? 3'd3 : (c == 52) ? 3'd4 : 3'd0;
      checks++;
      if (st !== exp_st) begin
        errors++; $display("FAIL cont_wind_down_c%0d got %0d want %0d", c, st, exp_st);
      end
    end
    ack = 1'b0;
  endtask

  task automatic test_abort;
    @(negedge clk); start = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c <= 6) begin
        checks++;
        if (st !== ((c == 1) ? 3'd1 : 3'd2)) begin
          errors++; $display("FAIL abort_pre_c%0d got st=%0d want %0d", c, st, (c == 1) ? 1 : 2);
        end
      end else begin
        checks++;
        if ({st, clr, en, rdy, bsy, res} !== {3'd0, 4'd0, 32'd10}) begin
          errors++; $display("FAIL abort_idle_c%0d got st=%0d clr=%b en=%b rdy=%b bsy=%b res=%0d want 0 0 0 0 0 10",
            c, st, clr, en, rdy, bsy, res);
        end
      end
      if (c == 6) abort = 1'b1;
    end
    abort = 1'b0; start = 1'b0;
    @(negedge clk);
    checks++;
    if ({st, res} !== {3'd0, 32'd10}) begin
      errors++; $display("FAIL abort_release got st=%0d res=%0d want 0 10", st, res);
    end
  endtask

  task automatic test_overflow(input int round);
    @(negedge clk); start2 = 1'b1;
    @(negedge clk); start2 = 1'b0;
    for (int i = 0; i < 40 && !(rdy20 === 1'b1 && rdy15 === 1'b1); i++) @(negedge clk);
    checks++;
    if (!(rdy20 === 1'b1 && rdy15 === 1'b1)) begin
      errors++; $display("FAIL ovf_timeout_r%0d got rdy20=%b rdy15=%b want 1 1", round, rdy20, rdy15);
    end
    checks++;
    if ({ovf20, res20} !== {1'b1, 4'd4}) begin
      errors++; $display("FAIL wrap20_r%0d got ovf=%b res=%0d want ovf=1 res=4", round, ovf20, res20);
    end
    checks++;
    if ({ovf15, res15} !== {1'b0, 4'd15}) begin
      errors++; $display("FAIL allones15_r%0d got ovf=%b res=%0d want ovf=0 res=15", round, ovf15, res15);
    end
    ack2 = 1'b1;
    @(negedge clk); ack2 = 1'b0;
    checks++;
    if ({bsy20, bsy15} !== 2'b00) begin
      errors++; $display("FAIL ovf_ack_r%0d got bsy20=%b bsy15=%b want 0 0", round, bsy20, bsy15);
    end
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; continuous = 1'b0; abort = 1'b0; ack = 1'b0;
    start2 = 1'b0; ack2 = 1'b0;
    test_reset();
    test_single_shot();
    test_handshake();
    test_continuous();
    test_abort();
    test_overflow(1);
    test_overflow(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
